// File: rtl/foo_pkg.sv
// Shared types and helpers for Foo-interface scope hubs.
// Sizes the client index and provides the lowest-set-bit search used by every arbiter.
package foo_pkg;

    localparam int unsigned MAX_CLIENTS = 16;

    typedef logic [3:0] client_id_t;

    // Returns 0 when no bit is set; callers qualify with their own any-set flag.
    function automatic client_id_t lowest_set_idx(input logic [MAX_CLIENTS-1:0] vec);
        client_id_t idx;
        idx = '0;
        for (int i = MAX_CLIENTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = client_id_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/quux_prio_arb.sv
// Combinational lowest-index priority encoder: one-hot grant, winner index and any-set flag.
// Used for both the in-scope and out-of-scope request vectors.
module quux_prio_arb
    import foo_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output client_id_t   idx_o,
    output logic         any_o
);

    logic [MAX_CLIENTS-1:0] req_ext;

    always_comb begin
        req_ext = MAX_CLIENTS'(req_i);
        idx_o   = lowest_set_idx(req_ext);
        any_o   = |req_i;
        gnt_o   = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/quux_scope_hub.sv
// Registered holder for the shared Foo signal quux; only in-scope clients may write it.
// Out-of-scope writes are dropped and reported as scope errors.
module quux_scope_hub
    import foo_pkg::*;
#(
    parameter int unsigned            NUM_CLIENTS = 4,
    parameter logic [NUM_CLIENTS-1:0] WRITE_MASK  = 4'b0001,
    parameter logic                   RESET_VAL   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] wr_req,
    input  logic [NUM_CLIENTS-1:0] wr_data,
    output logic [NUM_CLIENTS-1:0] wr_ack,
    output logic                   quux,
    output logic                   err_pulse,
    output logic [3:0]             err_client,
    output logic                   err_sticky,
    input  logic                   err_clr
);

    logic [NUM_CLIENTS-1:0] legal, illegal;
    logic [NUM_CLIENTS-1:0] legal_gnt, illegal_gnt;
    client_id_t             legal_idx, illegal_idx;
    logic                   legal_any, illegal_any;
    logic [MAX_CLIENTS-1:0] data_ext;
    logic                   unused_illegal_gnt;

    logic                   quux_q, quux_d;
    logic [NUM_CLIENTS-1:0] ack_q, ack_d;
    logic                   err_pulse_q, err_pulse_d;
    client_id_t             err_client_q, err_client_d;
    logic                   err_sticky_q, err_sticky_d;

    assign legal   = wr_req & WRITE_MASK;
    assign illegal = wr_req & ~WRITE_MASK;

    quux_prio_arb #(
        .N (NUM_CLIENTS)
    ) u_legal_arb (
        .req_i (legal),
        .gnt_o (legal_gnt),
        .idx_o (legal_idx),
        .any_o (legal_any)
    );

    quux_prio_arb #(
        .N (NUM_CLIENTS)
    ) u_illegal_arb (
        .req_i (illegal),
        .gnt_o (illegal_gnt),
        .idx_o (illegal_idx),
        .any_o (illegal_any)
    );

    // Only the index of the first offender is reported; the full grant is not needed.
    assign unused_illegal_gnt = ^illegal_gnt;

    always_comb begin
        data_ext     = MAX_CLIENTS'(wr_data);
        quux_d       = legal_any ? data_ext[legal_idx] : quux_q;
        ack_d        = legal_gnt;
        err_pulse_d  = illegal_any;
        err_client_d = illegal_any ? illegal_idx : err_client_q;
        // A new violation in the same cycle as err_clr keeps the flag set.
        if (illegal_any) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quux_q       <= RESET_VAL;
            ack_q        <= '0;
            err_pulse_q  <= 1'b0;
            err_client_q <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            quux_q       <= quux_d;
            ack_q        <= ack_d;
            err_pulse_q  <= err_pulse_d;
            err_client_q <= err_client_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign quux       = quux_q;
    assign wr_ack     = ack_q;
    assign err_pulse  = err_pulse_q;
    assign err_client = err_client_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_quux_scope_hub.sv
// Scoreboard bench for quux_scope_hub: the driver pushes expected outputs from a behavioural
// model, an independent monitor pops and compares one entry per clock.
module tb_quux_scope_hub;

    localparam int unsigned N     = 4;
    localparam logic [3:0]  MASK  = 4'b0101;
    localparam logic        RSTV  = 1'b0;

    typedef struct packed {
        logic       quux;
        logic [3:0] ack;
        logic       pulse;
        logic [3:0] client;
        logic       sticky;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] wr_req, wr_data, wr_ack, err_client;
    logic       quux, err_pulse, err_sticky, err_clr;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state
    logic       m_quux   = RSTV;
    logic [3:0] m_client = '0;
    logic       m_sticky = 1'b0;

    quux_scope_hub #(
        .NUM_CLIENTS (N),
        .WRITE_MASK  (MASK),
        .RESET_VAL   (RSTV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .quux       (quux),
        .err_pulse  (err_pulse),
        .err_client (err_client),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, req);
        end
    endtask

    // Drive one cycle of stimulus and push the outputs expected after the next edge.
    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] data,
                         input logic clr);
        exp_t       e;
        logic [3:0] ack;
        logic       pulse;
        @(negedge clk);
        rst_n   = rst;
        wr_req  = req;
        wr_data = data;
        err_clr = clr;
        ack     = '0;
        pulse   = 1'b0;
        if (!rst) begin
            m_quux   = RSTV;
            m_client = '0;
            m_sticky = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && MASK[i]) begin
                    ack[i] = 1'b1;
                    m_quux = data[i];
                    break;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !MASK[i]) begin
                    pulse    = 1'b1;
                    m_client = 4'(i);
                    break;
                end
            end
            if (pulse) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
        end
        e.quux   = m_quux;
        e.ack    = ack;
        e.pulse  = pulse;
        e.client = m_client;
        e.sticky = m_sticky;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("quux",       {3'b0, quux},       {3'b0, e.quux});
                chk("wr_ack",     wr_ack,             e.ack);
                chk("err_pulse",  {3'b0, err_pulse},  {3'b0, e.pulse});
                chk("err_client", err_client,         e.client);
                chk("err_sticky", {3'b0, err_sticky}, {3'b0, e.sticky});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cycle);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [3:0] pend;
        rst_n = 1'b0; wr_req = '0; wr_data = '0; err_clr = 1'b0;
        // Reset with every client requesting
        drive(1'b0, 4'b1111, 4'b1111, 1'b0);
        drive(1'b0, 4'b1111, 4'b1111, 1'b0);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0);
        // Legal writes by client 0
        drive(1'b1, 4'b0001, 4'b0001, 1'b0);
        drive(1'b1, 4'b0001, 4'b0000, 1'b0);
        // Out-of-scope write by client 1, then idle
        drive(1'b1, 4'b0010, 4'b0010, 1'b0);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0);
        // Priority between clients 0 and 2, client 2 holds
        drive(1'b1, 4'b0101, 4'b0001, 1'b0);
        drive(1'b1, 4'b0100, 4'b0000, 1'b0);
        // Legal and illegal together
        drive(1'b1, 4'b1011, 4'b0001, 1'b0);
        // err_clr alone, then clr racing a new violation
        drive(1'b1, 4'b0000, 4'b0000, 1'b1);
        drive(1'b1, 4'b1000, 4'b1000, 1'b0);
        drive(1'b1, 4'b0010, 4'b0000, 1'b1);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0);
        // Rewriting the current value still acks
        drive(1'b1, 4'b0100, 4'b0100, 1'b0);
        drive(1'b1, 4'b0100, 4'b0100, 1'b0);
        // Reset mid-operation discards pending requests
        drive(1'b0, 4'b0101, 4'b0000, 1'b0);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0);
        // Random traffic: clients hold requests until acked, with occasional early drops
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic       c;
            logic [3:0] d;
            pend = pend | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) pend = pend & 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 39) != 0);
            c = ($urandom_range(0, 7) == 0);
            d = 4'($urandom_range(0, 15));
            drive(r, pend, d, c);
            if (!r) begin
                pend = '0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (pend[i] && MASK[i]) begin
                        pend[i] = 1'b0;
                        break;
                    end
                end
                pend = pend & MASK;
            end
        end
        drive(1'b1, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain cycle=%0d actual=%0d required=0", cycle, exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quux_scope_hub.md
Name: quux_scope_hub

Overview:
- Registered holder for the single-bit shared signal `quux` carried by the Foo interface.
- Several client blocks request writes to `quux`. Only clients inside the owning scope, set by a permission mask, may change it.
- Writes from out-of-scope clients are rejected and reported as scope errors. These are hierarchy violations, such as a child writing `foo.quux` without owning it.
- Sits beside the Foo interface instance inside the parent module. All consumers read `quux` from this block.

Parameters:
- NUM_CLIENTS, 4, number of write-request clients (1..16).
- WRITE_MASK, 4'b0001, bit i=1 means client i is in scope and may write quux. Width is NUM_CLIENTS.
- RESET_VAL, 1'b0, value of quux after reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- wr_req  input  NUM_CLIENTS  per-client write request, one bit per client.
- wr_data  input  NUM_CLIENTS  per-client write value; bit i belongs to client i.
- wr_ack  output  NUM_CLIENTS  one-cycle pulse; bit i=1 when client i's write was applied.
- quux  output  1  current registered value of the shared signal.
- err_pulse  output  1  one-cycle pulse when at least one out-of-scope request occurred.
- err_client  output  4  lowest index among the out-of-scope requesters, registered with err_pulse.
- err_sticky  output  1  latched error flag.
- err_clr  input  1  clears err_sticky.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous, active-low on rst_n.
  - While rst_n=0 at a clk edge: quux=RESET_VAL, wr_ack=0, err_pulse=0, err_client=0, err_sticky=0.
- Request classification, each cycle:
  - legal = wr_req & WRITE_MASK.
  - illegal = wr_req & ~WRITE_MASK.
- Arbitration:
  - Among the legal requests, the lowest index wins.
  - Next cycle: quux <= wr_data[winner] and wr_ack[winner]=1.
  - All other bits of wr_ack are 0.
  - Latency is 1 cycle from request to both the quux update and the ack.
- Losing legal requesters:
  - They are not acked.
  - Each client must hold its request until acked. A client that drops its request early loses the write with no error.
- No legal request: quux holds its value and wr_ack=0.
- Writing the current value still acks, and quux is unchanged.
- Illegal requests:
  - Never modify quux and are never acked.
  - If illegal!=0, the next cycle gives err_pulse=1 and err_client=index of the lowest set bit of illegal.
  - err_client holds its last value when err_pulse=0.
  - err_sticky is set on any illegal request.
- Legal and illegal in the same cycle: the legal write proceeds normally and the error is also reported.
- err_clr:
  - err_clr=1 clears err_sticky next cycle.
  - If a new illegal request arrives in the same cycle, set wins: err_sticky stays 1.
- Reset asserted mid-operation: all pending requests are discarded with no ack. State returns to the reset values above.
- Edge cases:
  - WRITE_MASK=0: quux is constant RESET_VAL and every request is an error.
  - NUM_CLIENTS=1: priority logic degenerates to a direct path.

Decomposition:
- Shared package `foo_pkg`:
  - constant MAX_CLIENTS=16.
  - typedef client_id_t as logic[3:0].
  - Function `lowest_set_idx` (vector to index), used by both the arbiter and the error reporter.
- One natural sub-module: `quux_prio_arb`. It is a combinational lowest-index priority encoder that produces a one-hot grant, an index, and an any-set flag. It is instantiated twice: once for the legal vector, once for the illegal vector.
- The top level holds the quux, ack, and error registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with wr_req=4'b1111 -> quux=0, wr_ack=0, err_sticky=0. After release, quux stays 0 with no requests.
- Legal write: client0 wr_req[0]=1, wr_data[0]=1 -> next cycle quux=1, wr_ack=4'b0001, err_pulse=0. Then write 0 -> quux=0, ack again.
- Out-of-scope write: client2 requests with data 1, WRITE_MASK=4'b0001, quux=0 -> quux stays 0, wr_ack=0, err_pulse=1, err_client=2, err_sticky=1. Subsequent err_pulse=0 and err_sticky stays 1.
- Priority: WRITE_MASK=4'b0110; clients 1 and 2 request with data 1 and 0 -> quux=1, wr_ack=4'b0010. Client 2 holds its request -> next cycle quux=0, wr_ack=4'b0100.
- Simultaneous legal and illegal: with mask 4'b0001, client0 writes 1 while clients 3 and 1 request -> quux=1, wr_ack=4'b0001, err_pulse=1, err_client=1.
- err_clr race: with err_sticky=1, assert err_clr alone -> err_sticky=0. With err_sticky=1 again, assert err_clr together with an illegal request -> err_sticky remains 1.
